apb_timer_sched: RTL and testbench



---
 rtl/apb_timer_sched.sv | 153 +++++++++++++++
 tb/tb_apb_timer_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_sched.sv
// apb_timer_sched: round-robin scheduler that lends one APB timer to NREQ one-shot delay requesters
//   HCLK, HRESETn             clock, asynchronous active-low reset
//   req_valid_i/req_delay_i   per-requester request and 32-bit delay (slice i at [32*i+:32])
//   req_ready_o, done_o       one-hot accept and completion pulses
//   err_o                     one-hot overflow-abort pulse (only with APB_TIMER_SCHED_OVF_ABORT_EN)
//   busy_o                    high whenever a job is in flight
//   PADDR_o..PENABLE_o        APB master write port to the timer; PREADY_i is its ready
//   timer_irq_i               timer irq: bit1 compare match, bit0 overflow
// Optional feature macro: APB_TIMER_SCHED_OVF_ABORT_EN
module apb_timer_sched #(
    parameter int         NREQ           = 4,
    parameter int         APB_ADDR_WIDTH = 12,
    parameter logic [2:0] PRESCALER      = 3'd0
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [NREQ-1:0]           req_valid_i,
    input  logic [32*NREQ-1:0]        req_delay_i,
    output logic [NREQ-1:0]           req_ready_o,
    output logic [NREQ-1:0]           done_o,
`ifdef APB_TIMER_SCHED_OVF_ABORT_EN
    output logic [NREQ-1:0]           err_o,
`endif
    output logic                      busy_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR_o,
    output logic [31:0]               PWDATA_o,
    output logic                      PWRITE_o,
    output logic                      PSEL_o,
    output logic                      PENABLE_o,
    input  logic                      PREADY_i,
    input  logic [1:0]                timer_irq_i
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);
    localparam logic [APB_ADDR_WIDTH-1:0] CTRL_ADDR = APB_ADDR_WIDTH'(4);
    localparam logic [APB_ADDR_WIDTH-1:0] CMP_ADDR = APB_ADDR_WIDTH'(8);
    typedef enum logic [3:0] {IDLE, GRANT, CTRL_S, CTRL_A, CMP_S, CMP_A, WAIT, STOP_S, STOP_A, DONE} state_t;
    state_t        state_q;
    logic [IW-1:0] last_q, cur_q, win;
    logic [31:0]   dly_q, win_dly;
    logic          stop;
    // Scan from farthest to nearest after last_q so the nearest valid index is the final assignment.
    always_comb begin
        win = last_q;
        win_dly = '0;
        for (int k = NREQ; k >= 1; k--)
            for (int i = 0; i < NREQ; i++)
                if (i == (int'(last_q) + k) % NREQ && req_valid_i[i]) win = IW'(i);
        for (int i = 0; i < NREQ; i++)
            if (IW'(i) == win) win_dly = req_delay_i[32*i +: 32];
    end
`ifdef APB_TIMER_SCHED_OVF_ABORT_EN
    logic abort_q;
    assign stop = |timer_irq_i;
`else
    logic unused_ovf;
    assign unused_ovf = timer_irq_i[0];
    assign stop = timer_irq_i[1];
`endif
    assign busy_o = state_q != IDLE;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            last_q      <= IW'(NREQ - 1);
            cur_q       <= '0;
            dly_q       <= '0;
            req_ready_o <= '0;
            done_o      <= '0;
            PADDR_o     <= '0;
            PWDATA_o    <= '0;
            PWRITE_o    <= 1'b0;
            PSEL_o      <= 1'b0;
            PENABLE_o   <= 1'b0;
`ifdef APB_TIMER_SCHED_OVF_ABORT_EN
            err_o       <= '0;
            abort_q     <= 1'b0;
`endif
        end else begin
            req_ready_o <= '0;
            done_o      <= '0;
`ifdef APB_TIMER_SCHED_OVF_ABORT_EN
            err_o       <= '0;
`endif
            case (state_q)
                IDLE: if (|req_valid_i) begin
                    state_q     <= GRANT;
                    cur_q       <= win;
                    last_q      <= win;
                    dly_q       <= win_dly;
                    req_ready_o <= ONE << win;
                end
                GRANT: if (dly_q == '0) begin
                    state_q <= DONE;
                    done_o  <= ONE << cur_q;
                end else begin
                    state_q  <= CTRL_S;
                    PSEL_o   <= 1'b1;
                    PWRITE_o <= 1'b1;
                    PADDR_o  <= CTRL_ADDR;
                    PWDATA_o <= {26'b0, PRESCALER, 2'b0, 1'b1};
                end
                CTRL_S: begin
                    state_q   <= CTRL_A;
                    PENABLE_o <= 1'b1;
                end
                CTRL_A: if (PREADY_i) begin
                    state_q   <= CMP_S;
                    PENABLE_o <= 1'b0;
                    PADDR_o   <= CMP_ADDR;
                    PWDATA_o  <= dly_q;
                end
                CMP_S: begin
                    state_q   <= CMP_A;
                    PENABLE_o <= 1'b1;
                end
                CMP_A: if (PREADY_i) begin
                    state_q   <= WAIT;
                    PSEL_o    <= 1'b0;
                    PENABLE_o <= 1'b0;
                    PWRITE_o  <= 1'b0;
                end
                WAIT: if (stop) begin
                    state_q  <= STOP_S;
                    PSEL_o   <= 1'b1;
                    PWRITE_o <= 1'b1;
                    PADDR_o  <= CTRL_ADDR;
                    PWDATA_o <= '0;
`ifdef APB_TIMER_SCHED_OVF_ABORT_EN
                    abort_q  <= !timer_irq_i[1];
`endif
                end
                STOP_S: begin
                    state_q   <= STOP_A;
                    PENABLE_o <= 1'b1;
                end
                STOP_A: if (PREADY_i) begin
                    state_q   <= DONE;
                    PSEL_o    <= 1'b0;
                    PENABLE_o <= 1'b0;
                    PWRITE_o  <= 1'b0;
`ifdef APB_TIMER_SCHED_OVF_ABORT_EN
                    if (abort_q) err_o <= ONE << cur_q;
                    else done_o <= ONE << cur_q;
`else
                    done_o    <= ONE << cur_q;
`endif
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_timer_sched.sv
// tb_apb_timer_sched: randomized self-checking bench with a behavioural timer and scheduler model
module tb_apb_timer_sched;
    logic         HCLK = 1'b0;
    logic         HRESETn = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [31:0]  dly [4];
    logic [127:0] req_delay;
    logic [3:0]   req_ready, done, err_v;
    logic         busy, PWRITE, PSEL, PENABLE;
    logic         PREADY = 1'b1;
    logic         irq_force = 1'b0;
    logic [11:0]  PADDR;
    logic [31:0]  PWDATA;
    logic [1:0]   timer_irq;
    logic         tm_en, tm_armed;
    logic [31:0]  tm_rem;
    int           checks = 0, errors = 0, last_m = 3;

    always #5 HCLK = ~HCLK;
    assign req_delay = {dly[3], dly[2], dly[1], dly[0]};

`ifdef APB_TIMER_SCHED_OVF_ABORT_EN
    logic [3:0] err_o;
    assign err_v = err_o;
`else
    assign err_v = '0;
`endif

    apb_timer_sched dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid_i(req_valid), .req_delay_i(req_delay),
        .req_ready_o(req_ready), .done_o(done),
`ifdef APB_TIMER_SCHED_OVF_ABORT_EN
        .err_o(err_o),
`endif
        .busy_o(busy), .PADDR_o(PADDR), .PWDATA_o(PWDATA), .PWRITE_o(PWRITE),
        .PSEL_o(PSEL), .PENABLE_o(PENABLE), .PREADY_i(PREADY), .timer_irq_i(timer_irq)
    );

    // Timer: compare write loads the remaining ticks; match fires once when they run out while enabled.
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tm_en <= 1'b0; tm_armed <= 1'b0; tm_rem <= '0;
        end else if (PSEL && PENABLE && PREADY) begin
            if (PADDR == 12'h4) tm_en <= PWDATA[0];
            if (PADDR == 12'h8) begin tm_rem <= PWDATA; tm_armed <= 1'b1; end
        end else if (tm_armed && tm_en) begin
            if (tm_rem == 0) tm_armed <= 1'b0;
            else tm_rem <= tm_rem - 1;
        end
    end
    assign timer_irq = irq_force ? 2'b01 : {tm_armed && tm_en && tm_rem == 0, 1'b0};

    function automatic int rr(input int last, input logic [3:0] v);
        for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic idle(input int k);
        req_valid = '0;
        repeat (k) @(negedge HCLK);
    endtask

    task automatic do_reset(input string name);
        @(negedge HCLK);
        HRESETn = 1'b0; req_valid = '0; PREADY = 1'b1; irq_force = 1'b0; last_m = 3;
        #1;
        checks++;
        if ({req_ready, done, err_v, busy, PADDR, PWDATA, PWRITE, PSEL, PENABLE} !== '0) begin
            errors++;
            $display("FAIL %s: outputs rdy=%b done=%b err=%b busy=%b addr=%h data=%h w/s/e=%b%b%b, required all 0",
                     name, req_ready, done, err_v, busy, PADDR, PWDATA, PWRITE, PSEL, PENABLE);
        end
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    // Runs one job from the current point and checks it against the scheduling/timing rules.
    task automatic run_job(input logic [3:0] v, input bit hold, input int stall, input int ovf_after, input int exp_r);
        int w, r_cyc, c_cyc, irq_cyc, f_cyc, d_cyc, trig, stall_left, n_ready, busy_bad, pw_bad, stab_bad, psel_n;
        logic [31:0] d;
        logic [3:0]  rdy_v, done_v, err_seen, oh;
        bit ab;
        int wa[$], wd[$], wc[$];
        int ea[3], ed[3], ec[3];
        w = rr(last_m, v); d = dly[w]; oh = 4'(1 << w); ab = 1'b0;
`ifdef APB_TIMER_SCHED_OVF_ABORT_EN
        ab = ovf_after > 0;
`endif
        r_cyc = -1; c_cyc = -1; irq_cyc = -1; f_cyc = -1; d_cyc = -1;
        stall_left = stall; n_ready = 0; busy_bad = 0; pw_bad = 0; stab_bad = 0; psel_n = 0;
        rdy_v = '0; done_v = '0; err_seen = '0;
        req_valid = v;
        for (int n = 1; n <= 500 && d_cyc < 0; n++) begin
            @(negedge HCLK);
            irq_force = 1'b0;
            if (PSEL && !PENABLE && PADDR == 12'h8 && stall > 0) PREADY = 1'b0;
            if (PSEL && PENABLE && PADDR == 12'h8 && !PREADY) begin
                if (PWDATA !== d || PWRITE !== 1'b1) stab_bad++;
                if (stall_left > 0) stall_left--;
                else PREADY = 1'b1;
            end
            if (c_cyc >= 0 && ovf_after > 0 && n == c_cyc + ovf_after) begin irq_force = 1'b1; f_cyc = n; end
            if (req_ready != 0) begin
                n_ready++; rdy_v = req_ready;
                if (r_cyc < 0) r_cyc = n;
                if (!hold) req_valid = '0;
            end
            if (r_cyc >= 0 && busy !== 1'b1) busy_bad++;
            if (PSEL) begin psel_n++; if (PWRITE !== 1'b1) pw_bad++; end
            if (PSEL && PENABLE && PREADY) begin
                wa.push_back(int'(PADDR)); wd.push_back(int'(PWDATA)); wc.push_back(n);
                if (PADDR == 12'h8) c_cyc = n;
            end
            if (timer_irq[1] && irq_cyc < 0) irq_cyc = n;
            if (done != 0 || err_v != 0) begin d_cyc = n; done_v = done; err_seen = err_v; end
        end
        checks++;
        if (d_cyc < 0) begin
            errors++;
            $display("FAIL job_timeout: req%0d got no completion in 500 cycles, required one", w);
            return;
        end
        checks++;
        if (r_cyc !== exp_r) begin errors++; $display("FAIL ready_cycle: got %0d required %0d", r_cyc, exp_r); end
        checks++;
        if (rdy_v !== oh || n_ready != 1) begin
            errors++; $display("FAIL grant: ready=%b pulses=%0d required %b once", rdy_v, n_ready, oh);
        end
        checks++;
        if (busy_bad != 0 || pw_bad != 0 || stab_bad != 0) begin
            errors++; $display("FAIL apb_stable: busy_low=%0d pwrite_low=%0d cmp_unstable=%0d required 0/0/0", busy_bad, pw_bad, stab_bad);
        end
        if (d == 0) begin
            checks++;
            if (psel_n != 0 || d_cyc != r_cyc + 1) begin
                errors++; $display("FAIL zero_delay: psel_cycles=%0d done_at=%0d required 0 and %0d", psel_n, d_cyc, r_cyc + 1);
            end
        end else begin
            trig = ab ? f_cyc : irq_cyc;
            if (!ab) begin
                checks++;
                if (irq_cyc != r_cyc + 5 + stall + int'(d)) begin
                    errors++; $display("FAIL irq_cycle: got %0d required %0d", irq_cyc, r_cyc + 5 + stall + int'(d));
                end
            end
            ea = '{4, 8, 4}; ed = '{1, int'(d), 0}; ec = '{r_cyc + 2, r_cyc + 4 + stall, trig + 2};
            checks++;
            if (wa.size() != 3) begin
                errors++; $display("FAIL apb_count: got %0d writes required 3", wa.size());
            end else begin
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (wa[i] != ea[i] || wd[i] != ed[i] || wc[i] != ec[i]) begin
                        errors++;
                        $display("FAIL apb_write%0d: got %h<-%h @%0d required %h<-%h @%0d", i, wa[i], wd[i], wc[i], ea[i], ed[i], ec[i]);
                    end
                end
            end
            checks++;
            if (d_cyc != trig + 3) begin errors++; $display("FAIL done_cycle: got %0d required %0d", d_cyc, trig + 3); end
        end
        checks++;
        if (ab ? (done_v !== 4'b0 || err_seen !== oh) : (done_v !== oh || err_seen !== 4'b0)) begin
            errors++; $display("FAIL completion: done=%b err=%b required done=%b err=%b",
                               done_v, err_seen, ab ? 4'b0 : oh, ab ? oh : 4'b0);
        end
        last_m = w;
    endtask

    task automatic test_reset();
        do_reset("reset_state");
        @(negedge HCLK);
        checks++;
        if ({req_ready, done, busy, PSEL, PENABLE} !== '0) begin
            errors++; $display("FAIL post_reset_idle: rdy=%b done=%b busy=%b psel=%b required 0", req_ready, done, busy, PSEL);
        end
        for (int i = 0; i < 4; i++) dly[i] = $urandom_range(1, 8);
        run_job(4'b1111, 1'b0, 0, 0, 1);
    endtask

    task automatic test_single();
        idle(2);
        dly[1] = 5;
        run_job(4'b0010, 1'b0, 0, 0, 1);
    endtask

    task automatic test_round_robin();
        do_reset("rr_reset");
        for (int i = 0; i < 4; i++) dly[i] = $urandom_range(1, 10);
        run_job(4'b1011, 1'b1, 0, 0, 1);
        run_job(4'b1011, 1'b1, 0, 0, 2);
        run_job(4'b1011, 1'b1, 0, 0, 2);
        idle(2);
    endtask

    task automatic test_zero_delay();
        idle(2);
        dly[2] = 0;
        run_job(4'b0100, 1'b0, 0, 0, 1);
    endtask

    task automatic test_stall();
        idle(2);
        dly[3] = $urandom_range(1, 9);
        run_job(4'b1000, 1'b0, 2, 0, 1);
    endtask

    task automatic test_back_to_back();
        idle(2);
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 4; i++) dly[i] = $urandom_range(0, 12);
            run_job(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0, j == 0 ? 1 : 2);
        end
        idle(2);
    endtask

    task automatic test_overflow();
        idle(2);
`ifdef APB_TIMER_SCHED_OVF_ABORT_EN
        dly[0] = 40;
`else
        dly[0] = 10;
`endif
        run_job(4'b0001, 1'b0, 0, 3, 1);
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        idle(2);
        dly[2] = 60; seen = 1'b0;
        req_valid = 4'b0100;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge HCLK);
            if (PSEL && PENABLE && PADDR == 12'h8) seen = 1'b1;
        end
        req_valid = '0;
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_wait_setup: compare write seen=%b required 1", seen); end
        repeat (5) @(negedge HCLK);
        checks++;
        if (busy !== 1'b1 || PADDR !== 12'h8) begin
            errors++; $display("FAIL mid_wait_busy: busy=%b addr=%h required 1 and 008", busy, PADDR);
        end
        do_reset("mid_wait_reset");
        dly[3] = 3;
        run_job(4'b1000, 1'b0, 0, 0, 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_delay();
        test_stall();
        test_back_to_back();
        test_overflow();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
